// File: rtl/contra_scroll_tile_mapper.sv
// Tile-map background renderer with wrapping horizontal scroll and a 4-stage ROM lookup pipeline.
// Optional per-tile mirroring is enabled by defining CONTRA_MAP_FLIP_EN.
module contra_scroll_tile_mapper #(
    parameter int SCALE       = 2,
    parameter int TILE_W      = 16,
    parameter int TILE_H      = 16,
    parameter int MAP_COLS    = 64,
    parameter int MAP_ROWS    = 15,
    parameter int TILE_IDX_W  = 6,
    parameter int COLOR_IDX_W = 5,
    parameter int STEP_W      = 4
) (
    input  logic                                          vga_clk,
    input  logic                                          reset,
    input  logic [9:0]                                    DrawX,
    input  logic [9:0]                                    DrawY,
    input  logic                                          blank,
    input  logic                                          frame_start,
    input  logic                                          scroll_wr,
    input  logic [$clog2(MAP_COLS*TILE_W)-1:0]            scroll_in,
    input  logic                                          auto_en,
    input  logic [STEP_W-1:0]                             auto_step,
    output logic [$clog2(MAP_COLS*MAP_ROWS)-1:0]          map_addr,
`ifdef CONTRA_MAP_FLIP_EN
    input  logic [TILE_IDX_W+1:0]                         map_q,
`else
    input  logic [TILE_IDX_W-1:0]                         map_q,
`endif
    output logic [TILE_IDX_W+$clog2(TILE_W*TILE_H)-1:0]   pix_addr,
    input  logic [COLOR_IDX_W-1:0]                        pix_q,
    output logic [COLOR_IDX_W-1:0]                        pal_index,
    input  logic [3:0]                                    pal_r,
    input  logic [3:0]                                    pal_g,
    input  logic [3:0]                                    pal_b,
    output logic [3:0]                                    red,
    output logic [3:0]                                    green,
    output logic [3:0]                                    blue,
    output logic [$clog2(MAP_COLS*TILE_W)-1:0]            scroll_cur
);

    localparam int SX_W = $clog2(MAP_COLS*TILE_W);
    localparam int MA_W = $clog2(MAP_COLS*MAP_ROWS);
    localparam int SC_B = $clog2(SCALE);
    localparam int TW_B = $clog2(TILE_W);
    localparam int TH_B = $clog2(TILE_H);

    typedef enum logic {IDLE, PENDING} scroll_state_t;

    scroll_state_t   state, state_n;
    logic [SX_W-1:0] shadow, shadow_n, scroll_n;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            scroll_cur <= '0;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            scroll_cur <= scroll_n;
        end
    end

    // A write coinciding with frame_start bypasses the shadow and takes effect at once.
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        scroll_n = scroll_cur;
        if (scroll_wr && frame_start) begin
            scroll_n = scroll_in;
            state_n  = IDLE;
        end else if (scroll_wr) begin
            shadow_n = scroll_in;
            state_n  = PENDING;
        end else if (frame_start) begin
            if (state == PENDING) begin
                scroll_n = shadow;
                state_n  = IDLE;
            end else if (auto_en) begin
                scroll_n = scroll_cur + SX_W'(auto_step);
            end
        end
    end

    logic [9:0]      tx, ty;
    logic [SX_W-1:0] tx_w;
    logic [MA_W-1:0] map_addr_c;

    always_comb begin
        tx         = DrawX >> SC_B;
        ty         = DrawY >> SC_B;
        tx_w       = SX_W'(tx) + scroll_cur;
        map_addr_c = MA_W'((32'(ty) >> TH_B) * MAP_COLS + 32'(tx_w >> TW_B));
    end

    logic [TW_B-1:0]       sub_x1, sx_c;
    logic [TH_B-1:0]       sub_y1, sy_c;
    logic [TILE_IDX_W-1:0] idx_c;
    logic                  blank1, blank2, blank3;

    always_comb begin
        idx_c = map_q[TILE_IDX_W-1:0];
        sx_c  = sub_x1;
        sy_c  = sub_y1;
`ifdef CONTRA_MAP_FLIP_EN
        if (map_q[TILE_IDX_W])
            sx_c = TW_B'(TILE_W-1) - sub_x1;
        if (map_q[TILE_IDX_W+1])
            sy_c = TH_B'(TILE_H-1) - sub_y1;
`endif
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            map_addr  <= '0;
            sub_x1    <= '0;
            sub_y1    <= '0;
            blank1    <= 1'b0;
            pix_addr  <= '0;
            blank2    <= 1'b0;
            pal_index <= '0;
            blank3    <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            map_addr  <= map_addr_c;
            sub_x1    <= tx_w[TW_B-1:0];
            sub_y1    <= ty[TH_B-1:0];
            blank1    <= blank;
            pix_addr  <= {idx_c, sy_c, sx_c};
            blank2    <= blank1;
            pal_index <= pix_q;
            blank3    <= blank2;
            red       <= blank3 ? pal_r : '0;
            green     <= blank3 ? pal_g : '0;
            blue      <= blank3 ? pal_b : '0;
        end
    end

endmodule

// File: tb/tb_contra_scroll_tile_mapper.sv
// Directed bench for contra_scroll_tile_mapper: pipeline latency, address math, scroll control.
module tb_contra_scroll_tile_mapper;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_start, scroll_wr, auto_en;
    logic [9:0]  scroll_in;
    logic [3:0]  auto_step;
    logic [9:0]  map_addr;
    logic [13:0] pix_addr;
    logic [4:0]  pix_q, pal_index;
    logic [3:0]  pal_r, pal_g, pal_b, red, green, blue;
    logic [9:0]  scroll_cur;
    logic [5:0]  map_idx;
    logic [1:0]  flip_bits;
`ifdef CONTRA_MAP_FLIP_EN
    logic [7:0]  map_q;
    assign map_q = {flip_bits, map_idx};
`else
    logic [5:0]  map_q;
    assign map_q = map_idx;
`endif

    int errors = 0;
    int checks = 0;

    always #5 vga_clk = ~vga_clk;

    // External ROM / palette models: map idx = addr+4 mod 64, texel = low 5 address bits.
    assign map_idx = map_addr[5:0] + 6'd4;
    assign pix_q   = pix_addr[4:0];
    assign pal_r   = pal_index[3:0];
    assign pal_g   = {pal_index[4], pal_index[2:0]};
    assign pal_b   = pal_index[3:0] + 4'd1;

    contra_scroll_tile_mapper dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .scroll_wr(scroll_wr), .scroll_in(scroll_in),
        .auto_en(auto_en), .auto_step(auto_step), .map_addr(map_addr), .map_q(map_q),
        .pix_addr(pix_addr), .pix_q(pix_q), .pal_index(pal_index),
        .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
        .red(red), .green(green), .blue(blue), .scroll_cur(scroll_cur)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    initial begin
        reset = 1'b1; DrawX = 10'd34; DrawY = 10'd70; blank = 1'b1;
        frame_start = 1'b0; scroll_wr = 1'b0; scroll_in = '0;
        auto_en = 1'b0; auto_step = 4'd0; flip_bits = 2'b00;

        tick(3);
        check("reset_red", red, 0);
        check("reset_green", green, 0);
        check("reset_scroll", scroll_cur, 0);
        check("reset_map_addr", map_addr, 0);

        // DrawX=34 DrawY=70: col 1 row 2, sub (1,3); idx 5 -> texel 1329 -> colour 17
        reset = 1'b0;
        tick(1);
        check("map_addr_n1", map_addr, 129);
        tick(1);
        check("pix_addr_n2", pix_addr, 1329);
        tick(1);
        check("pal_index_n3", pal_index, 17);
        check("red_still_black_n3", red, 0);
        tick(1);
        check("red_n4", red, 1);
        check("green_n4", green, 9);
        check("blue_n4", blue, 2);

        blank = 1'b0;
        tick(4);
        check("blank_pal_index", pal_index, 17);
        check("blank_red", red, 0);
        check("blank_green", green, 0);
        check("blank_blue", blue, 0);
        blank = 1'b1;

        scroll_in = 10'd40; scroll_wr = 1'b1;
        tick(1);
        scroll_wr = 1'b0;
        check("wr_no_apply", scroll_cur, 0);
        tick(2);
        check("wr_hold", scroll_cur, 0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("wr_apply_40", scroll_cur, 40);

        scroll_in = 10'd52; scroll_wr = 1'b1;
        tick(1);
        scroll_in = 10'd48;
        tick(1);
        scroll_wr = 1'b0;
        check("wr2_no_apply", scroll_cur, 40);
        frame_start = 1'b1;
        tick(1);
        check("last_write_wins", scroll_cur, 48);
        tick(1);
        frame_start = 1'b0;
        check("idle_no_auto", scroll_cur, 48);

        // Same-cycle write + frame_start; DrawX=10 -> tx 5 + 1020 wraps to 1
        scroll_in = 10'd1020; scroll_wr = 1'b1; frame_start = 1'b1; DrawX = 10'd10;
        tick(1);
        scroll_wr = 1'b0; frame_start = 1'b0;
        check("wr_fs_immediate", scroll_cur, 1020);
        tick(1);
        check("wrap_map_addr", map_addr, 128);
        tick(1);
        check("wrap_pix_addr", pix_addr, 1073);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("wr_fs_stays_idle", scroll_cur, 1020);

        scroll_in = 10'd1022; scroll_wr = 1'b1; frame_start = 1'b1;
        tick(1);
        scroll_wr = 1'b0; frame_start = 1'b0;
        check("set_1022", scroll_cur, 1022);
        auto_en = 1'b1; auto_step = 4'd3;
        tick(2);
        check("auto_waits_frame", scroll_cur, 1022);
        frame_start = 1'b1;
        tick(1);
        check("auto_wrap", scroll_cur, 1);
        tick(1);
        frame_start = 1'b0;
        check("auto_step2", scroll_cur, 4);
        scroll_in = 10'd100; scroll_wr = 1'b1;
        tick(1);
        scroll_wr = 1'b0;
        frame_start = 1'b1;
        tick(1);
        check("pending_beats_auto", scroll_cur, 100);
        tick(1);
        frame_start = 1'b0;
        check("auto_resumes", scroll_cur, 103);
        auto_en = 1'b0;

        // scroll 103, DrawX=22 -> tx_w 114: col 7, sub-x 2; idx 11
        DrawX = 10'd22; flip_bits = 2'b01;
        tick(1);
        check("flip_map_addr", map_addr, 135);
        tick(1);
`ifdef CONTRA_MAP_FLIP_EN
        check("hflip_pix_addr", pix_addr, 2877);
`else
        check("noflip_pix_addr", pix_addr, 2866);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
